// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared types and helpers for the LED matrix scan driver
package led_matrix_pkg;

    // Scan FSM: all-off blanking gap, then the lit dwell window of one row
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    // Widest pin group the polarity helper handles
    localparam int POL_MAX = 64;

    // Row index width; never below one bit so the index is always a real vector
    function automatic int row_idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Turns "1 = active" bits into pin levels
    function automatic logic [POL_MAX-1:0] apply_polarity(input logic [POL_MAX-1:0] active_bits,
                                                          input logic             active_low);
        return active_low ? ~active_bits : active_bits;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// rtl/led_matrix_scanner_if.sv - application-side write/swap/brightness port of the scanner
interface led_matrix_scanner_if #(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 4
);
    import led_matrix_pkg::*;

    localparam int RW = row_idx_width(ROWS);

    logic                wr_en;
    logic [RW-1:0]       wr_row;
    logic [COLS-1:0]     wr_data;
    logic                swap_req;
    logic                swap_done;
    logic [PWM_BITS-1:0] brightness;

    modport master (
        output wr_en, wr_row, wr_data, swap_req, brightness,
        input  swap_done
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req, brightness,
        output swap_done
    );

endinterface

// File: rtl/led_frame_buffer.sv
// rtl/led_frame_buffer.sv - two-bank ROWS x COLS frame store with back-bank writes and bank flip
module led_frame_buffer #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    parameter int RW   = 2
) (
    input  logic            clk12MHz,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            flip,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);

    logic [COLS-1:0] mem [2][ROWS];
    logic            front;
    logic            row_ok;

    // Out-of-range rows only exist when ROWS is not a power of two
    generate
        if ((1 << RW) == ROWS) begin : g_full_range
            assign row_ok = 1'b1;
        end else begin : g_partial_range
            assign row_ok = (wr_row < RW'(ROWS));
        end
    endgenerate

    // Writes always land in the bank not on display; a write coinciding
    // with a flip hits the old back bank and so is shown straight away
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            front <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else begin
            if (wr_en && row_ok) begin
                mem[~front][wr_row] <= wr_data;
            end
            if (flip) begin
                front <= ~front;
            end
        end
    end

    assign rd_data = mem[front][rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - blanked, PWM-dimmed, double-buffered LED matrix row scanner
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 8,
    parameter int DWELL_BITS     = 10,
    parameter int PWM_BITS       = 4,
    parameter int BLANK_CYCLES   = 16,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                 clk12MHz,
    input  logic                 reset,
    led_matrix_scanner_if.slave  bus,
    output logic                 frame_start,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_drive
);

    localparam int RW  = row_idx_width(ROWS);
    localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_CYCLES - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
    localparam logic           ROW_LOW    = (ROW_ACTIVE_LOW != 0);
    localparam logic           COL_LOW    = (COL_ACTIVE_LOW != 0);
    localparam logic [ROWS-1:0] ROW_IDLE  = ROWS'(apply_polarity('0, ROW_LOW));
    localparam logic [COLS-1:0] COL_IDLE  = COLS'(apply_polarity('0, COL_LOW));

    scan_state_t           state, state_d;
    logic [RW-1:0]         cur_row, row_d;
    logic [BCW-1:0]        blank_cnt, blank_d;
    logic [DWELL_BITS-1:0] dwell_cnt, dwell_d;
    logic [PWM_BITS-1:0]   bright_q, bright_d;
    logic                  swap_pend, swap_pend_d;
    logic                  flip;

    logic [COLS-1:0]       front_row;
    logic [PWM_BITS-1:0]   pwm_phase;
    logic [ROWS-1:0]       row_on;
    logic [COLS-1:0]       col_on;
    logic                  first_blank;

    led_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW)
    ) u_frame_buffer (
        .clk12MHz (clk12MHz),
        .reset    (reset),
        .wr_en    (bus.wr_en),
        .wr_row   (bus.wr_row),
        .wr_data  (bus.wr_data),
        .flip     (flip),
        .rd_row   (cur_row),
        .rd_data  (front_row)
    );

    // Scan state register
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state     <= ST_BLANK;
            cur_row   <= '0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            bright_q  <= '0;
            swap_pend <= 1'b0;
        end else begin
            state     <= state_d;
            cur_row   <= row_d;
            blank_cnt <= blank_d;
            dwell_cnt <= dwell_d;
            bright_q  <= bright_d;
            swap_pend <= swap_pend_d;
        end
    end

    // Next-state: blank gap, dwell window, row advance and frame-boundary flip
    always_comb begin
        state_d     = state;
        row_d       = cur_row;
        blank_d     = blank_cnt;
        dwell_d     = dwell_cnt;
        bright_d    = bright_q;
        flip        = 1'b0;
        swap_pend_d = swap_pend | bus.swap_req;
        case (state)
            ST_BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_d  = ST_ON;
                    blank_d  = '0;
                    dwell_d  = '0;
                    bright_d = bus.brightness;
                end else begin
                    blank_d = blank_cnt + 1'b1;
                end
            end
            ST_ON: begin
                dwell_d = dwell_cnt + 1'b1;
                if (dwell_cnt == '1) begin
                    state_d = ST_BLANK;
                    if (cur_row == ROW_LAST) begin
                        row_d = '0;
                        if (swap_pend_d) begin
                            flip        = 1'b1;
                            swap_pend_d = 1'b0;
                        end
                    end else begin
                        row_d = cur_row + 1'b1;
                    end
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    assign pwm_phase   = dwell_cnt[DWELL_BITS-1 -: PWM_BITS];
    assign first_blank = (state == ST_BLANK) && (cur_row == '0) && (blank_cnt == '0);

    // Active-high pin picture of the current cycle, before polarity
    always_comb begin
        row_on = '0;
        col_on = '0;
        if (state == ST_ON) begin
            row_on[cur_row] = 1'b1;
            if (pwm_phase < bright_q) begin
                col_on = front_row;
            end
        end
    end

    // Output registers: pins trail the scan state by one clock
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            row_sel       <= ROW_IDLE;
            col_drive     <= COL_IDLE;
            frame_start   <= 1'b0;
            bus.swap_done <= 1'b0;
        end else begin
            row_sel       <= ROWS'(apply_polarity(POL_MAX'(row_on), ROW_LOW));
            col_drive     <= COLS'(apply_polarity(POL_MAX'(col_on), COL_LOW));
            frame_start   <= first_blank;
            bus.swap_done <= flip;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - directed table-driven bench for led_matrix_scanner
module tb_led_matrix_scanner;

    logic       clk12MHz = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [3:0] row_sel;
    logic [7:0] col_drive;

    led_matrix_scanner_if #(.ROWS(4), .COLS(8), .PWM_BITS(2)) bus ();

    led_matrix_scanner #(
        .ROWS           (4),
        .COLS           (8),
        .DWELL_BITS     (4),
        .PWM_BITS       (2),
        .BLANK_CYCLES   (2),
        .ROW_ACTIVE_LOW (1),
        .COL_ACTIVE_LOW (1)
    ) dut (
        .clk12MHz    (clk12MHz),
        .reset       (reset),
        .bus         (bus),
        .frame_start (frame_start),
        .row_sel     (row_sel),
        .col_drive   (col_drive)
    );

    always #5 clk12MHz = ~clk12MHz;

    typedef struct {
        int         pc;
        logic [3:0] rs;
        logic [7:0] cd;
        logic       fs;
        logic       sd;
        logic       do_wr;
        logic [1:0] wrow;
        logic [7:0] wdata;
        logic       do_swap;
        int         br;
    } vec_t;

    vec_t tab[$];
    int   errors = 0;
    int   checks = 0;
    int   pc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pc=%0d got=%0h want=%0h", name, pc, act, exp);
        end
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] rs, input logic [7:0] cd,
                            input logic fs, input logic sd);
        chk({tag, ".row_sel"},     32'(row_sel),       32'(rs));
        chk({tag, ".col_drive"},   32'(col_drive),     32'(cd));
        chk({tag, ".frame_start"}, 32'(frame_start),   32'(fs));
        chk({tag, ".swap_done"},   32'(bus.swap_done), 32'(sd));
    endtask

    // Advance to pin cycle 'target'; single-cycle pulses are dropped on each step
    task automatic step_to(input int target);
        while (pc < target) begin
            @(negedge clk12MHz);
            pc++;
            bus.wr_en    = 1'b0;
            bus.swap_req = 1'b0;
        end
    endtask

    task automatic add(input int p, input logic [3:0] rs, input logic [7:0] cd,
                       input logic fs, input logic sd);
        vec_t v;
        v.pc = p; v.rs = rs; v.cd = cd; v.fs = fs; v.sd = sd;
        v.do_wr = 1'b0; v.wrow = '0; v.wdata = '0; v.do_swap = 1'b0; v.br = -1;
        tab.push_back(v);
    endtask

    task automatic act_wr(input logic [1:0] r, input logic [7:0] d);
        tab[tab.size()-1].do_wr = 1'b1;
        tab[tab.size()-1].wrow  = r;
        tab[tab.size()-1].wdata = d;
    endtask

    task automatic act_swap();
        tab[tab.size()-1].do_swap = 1'b1;
    endtask

    task automatic act_br(input int b);
        tab[tab.size()-1].br = b;
    endtask

    initial begin
        reset          = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_row     = '0;
        bus.wr_data    = '0;
        bus.swap_req   = 1'b0;
        bus.brightness = 2'd3;

        // Frame 0: empty buffers, scan order and blanking; load back bank, double swap request
        add(0, 4'hF, 8'hFF, 1, 0);  add(1, 4'hF, 8'hFF, 0, 0);
        add(2, 4'hE, 8'hFF, 0, 0);  add(17, 4'hE, 8'hFF, 0, 0);
        add(18, 4'hF, 8'hFF, 0, 0); add(19, 4'hF, 8'hFF, 0, 0);
        add(20, 4'hD, 8'hFF, 0, 0); add(38, 4'hB, 8'hFF, 0, 0);
        add(53, 4'hB, 8'hFF, 0, 0); add(54, 4'hF, 8'hFF, 0, 0);
        add(56, 4'h7, 8'hFF, 0, 0);
        add(60, 4'h7, 8'hFF, 0, 0); act_wr(2'd0, 8'h01);
        add(61, 4'h7, 8'hFF, 0, 0); act_wr(2'd1, 8'h80);
        add(62, 4'h7, 8'hFF, 0, 0); act_wr(2'd2, 8'hAA);
        add(63, 4'h7, 8'hFF, 0, 0); act_wr(2'd3, 8'h55);
        add(64, 4'h7, 8'hFF, 0, 0); act_swap();
        add(65, 4'h7, 8'hFF, 0, 0); act_swap();
        add(70, 4'h7, 8'hFF, 0, 0); add(71, 4'h7, 8'hFF, 0, 1);
        // Frame 1: new bank shown at brightness 3 (12 of 16 lit)
        add(72, 4'hF, 8'hFF, 1, 0); add(74, 4'hE, 8'hFE, 0, 0);
        add(85, 4'hE, 8'hFE, 0, 0); add(86, 4'hE, 8'hFF, 0, 0);
        add(92, 4'hD, 8'h7F, 0, 0); add(110, 4'hB, 8'h55, 0, 0);
        add(128, 4'h7, 8'hAA, 0, 0);
        add(130, 4'h7, 8'hAA, 0, 0); act_wr(2'd0, 8'hFF);
        add(131, 4'h7, 8'hAA, 0, 0); act_swap(); act_br(1);
        add(143, 4'h7, 8'hFF, 0, 1);
        // Frame 2: row 0 = FF at brightness 1 (4 of 16 lit)
        add(144, 4'hF, 8'hFF, 1, 0); add(146, 4'hE, 8'h00, 0, 0);
        add(149, 4'hE, 8'h00, 0, 0);
        add(150, 4'hE, 8'hFF, 0, 0); act_br(3);
        add(161, 4'hE, 8'hFF, 0, 0); add(164, 4'hD, 8'hFF, 0, 0);
        add(215, 4'h7, 8'hFF, 0, 0);
        // Frame 3: brightness dropped mid-row, current row keeps duty 3
        add(216, 4'hF, 8'hFF, 1, 0); add(218, 4'hE, 8'h00, 0, 0);
        add(222, 4'hE, 8'h00, 0, 0); act_br(1);
        add(229, 4'hE, 8'h00, 0, 0); add(230, 4'hE, 8'hFF, 0, 0);
        add(287, 4'h7, 8'hFF, 0, 0);
        // Frame 4: new duty 1 in effect; then brightness 0
        add(290, 4'hE, 8'h00, 0, 0); add(293, 4'hE, 8'h00, 0, 0);
        add(294, 4'hE, 8'hFF, 0, 0); act_br(0);
        // Frame 5: dark row; swap pending and write issued in the flip cycle
        add(362, 4'hE, 8'hFF, 0, 0); act_br(3); act_swap();
        add(430, 4'h7, 8'hFF, 0, 0); act_wr(2'd2, 8'h0F);
        add(431, 4'h7, 8'hFF, 0, 1);
        // Frame 6: flip-cycle write visible at once
        add(432, 4'hF, 8'hFF, 1, 0); add(434, 4'hE, 8'hFE, 0, 0);
        add(470, 4'hB, 8'hF0, 0, 0); add(488, 4'h7, 8'hAA, 0, 0);

        repeat (3) @(negedge clk12MHz);
        chk_pins("reset", 4'hF, 8'hFF, 0, 0);
        reset = 1'b0;
        @(negedge clk12MHz);
        pc = 0;

        for (int i = 0; i < tab.size(); i++) begin
            step_to(tab[i].pc);
            chk_pins($sformatf("vec%0d", i), tab[i].rs, tab[i].cd, tab[i].fs, tab[i].sd);
            if (tab[i].do_wr) begin
                bus.wr_en   = 1'b1;
                bus.wr_row  = tab[i].wrow;
                bus.wr_data = tab[i].wdata;
            end
            if (tab[i].do_swap) begin
                bus.swap_req = 1'b1;
            end
            if (tab[i].br >= 0) begin
                bus.brightness = 2'(tab[i].br);
            end
        end

        // Reset in the middle of row 2's ON window, with a swap request held through it
        step_to(550);
        chk_pins("row2_pre_reset", 4'hB, 8'hF0, 0, 0);
        reset        = 1'b1;
        bus.swap_req = 1'b1;
        @(negedge clk12MHz);
        chk_pins("mid_reset", 4'hF, 8'hFF, 0, 0);
        @(negedge clk12MHz);
        reset        = 1'b0;
        bus.swap_req = 1'b0;
        @(negedge clk12MHz);
        pc = 0;
        chk_pins("post_reset_start", 4'hF, 8'hFF, 1, 0);
        step_to(2);
        chk_pins("post_reset_row0", 4'hE, 8'hFF, 0, 0);
        step_to(38);
        chk_pins("post_reset_row2", 4'hB, 8'hFF, 0, 0);
        step_to(71);
        chk_pins("post_reset_no_swap", 4'h7, 8'hFF, 0, 0);
        step_to(72);
        chk_pins("post_reset_frame", 4'hF, 8'hFF, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
